io_input_conditioner: RTL and testbench
=======================================

# io_input_conditioner

Conditions the raw board inputs (slide switches, push-buttons) before they reach the memory-mapped input buffer of the LSU at 0x7800–0x781F. Every input bit is synchronised into the core clock domain and debounced with a shared sampling prescaler. The block drives the LSU's `i_io_sw` / `i_io_btn` buses, plus one-cycle button-press pulses for future interrupt/event logic. It sits directly upstream of the LSU input buffer, between the FPGA pins and the core.

## Interface
Parameters:
- `SW_WIDTH`, 32, number of switch bits.
- `BTN_WIDTH`, 4, number of button bits.
- `SYNC_STAGES`, 2, flip-flops in each synchroniser chain (≥2).
- `TICK_CYCLES`, 500000, clock cycles per debounce sample tick (10 ms at 50 MHz). Must be ≥2.
- `DB_TICKS`, 4, consecutive differing samples required to accept a new level (≥2).
- `BTN_ACTIVE_LOW`, 1, when 1 the raw buttons are inverted so that `o_io_btn` = 1 means pressed.

Ports:
- `i_clk`, in, 1: core clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_sw_raw`, in, `SW_WIDTH`: raw switch pins, asynchronous to `i_clk`.
- `i_btn_raw`, in, `BTN_WIDTH`: raw button pins, asynchronous to `i_clk`.
- `o_io_sw`, out, `SW_WIDTH`: debounced switch levels, feeding LSU `i_io_sw`.
- `o_io_btn`, out, `BTN_WIDTH`: debounced button levels, 1 = pressed, feeding LSU `i_io_btn`.
- `o_btn_press`, out, `BTN_WIDTH`: one-cycle pulse per debounced press.

## Operation
- **Polarity:** buttons are inverted at the input when `BTN_ACTIVE_LOW` = 1. All later logic uses the active-high convention.
- **Synchroniser:** each bit passes through a `SYNC_STAGES` chain.
  - Switch chains reset to 0.
  - Button chains reset to 0 after inversion, i.e. "not pressed".
- **Prescaler:** one shared counter runs 0..`TICK_CYCLES`-1.
  - `tick` is asserted for one cycle when the count equals `TICK_CYCLES`-1; the count then wraps to 0.
  - Reset value of the count is 0.
- **Per-bit debouncer:** holds a stable level `stb` and a sample counter `cnt`, width `$clog2(DB_TICKS)`. Both reset to 0. State updates on tick cycles only:
  - Synchronised bit equals `stb`: `cnt` ← 0.
  - Synchronised bit differs from `stb` and `cnt` < `DB_TICKS`-1: `cnt` ← `cnt`+1.
  - Synchronised bit differs from `stb` and `cnt` = `DB_TICKS`-1: `stb` ← synchronised bit, `cnt` ← 0.
  - Pulses shorter than one tick that fall between ticks are ignored. This is intended.
- **Outputs:**
  - `o_io_sw` and `o_io_btn` are the `stb` registers, with no further logic.
  - `o_btn_press[i]` is a registered pulse, set on the same clock edge where `stb[i]` goes 0→1. It is high for exactly one cycle, in the first cycle `o_io_btn[i]` reads 1.
  - A release (1→0) produces no pulse.
- **Independence:** bits are fully independent. Simultaneous changes on several bits each debounce separately, and several press pulses may coincide.

## Timing
- **Reset values:** every output is 0 while `i_rst` is high and until the first accepted change.
- **Asynchronous assertion:** asserting `i_rst` mid-debounce clears all of the following immediately, without a clock edge: sync chains, prescaler, `cnt`, `stb`, and pulses.
- **Reset release:** prescaler starts at 0, so the first tick occurs `TICK_CYCLES`-1 cycles after the first active edge.
- **Latency** from a clean raw edge, held steady, to the output change:
  - Minimum: `SYNC_STAGES` + 1 + (`DB_TICKS`-1)·`TICK_CYCLES` cycles.
  - Maximum: `SYNC_STAGES` + `DB_TICKS`·`TICK_CYCLES` cycles.
- **Bounce:** any tick that samples the old level restarts the count, so a bouncing input extends latency until it has been steady for `DB_TICKS` ticks.
- **Downstream timing:** outputs are registered and change only on `i_clk` edges. The LSU's combinational read therefore sees a glitch-free level.

## Structure
- **Shared package `io_pkg`:** default constants for `SW_WIDTH`, `BTN_WIDTH`, `TICK_CYCLES` and `DB_TICKS`. The LSU input-buffer address constants (`SWITCH_ADDR` 0x00, `BUTTON_ADDR` 0x10) move into the same package so that both blocks share one definition.
- **Sub-module `debounce_bit`:** one instance per bit, generated `SW_WIDTH`+`BTN_WIDTH` times.
  - Contains the sync chain, `cnt` and `stb`.
  - Inputs: `tick` and the raw bit.
  - Outputs: the stable level and the rise pulse. The rise pulse is used for buttons only.
- **Top level:** holds the prescaler and the polarity inversion only.

## Test plan
Bench parameters for all scenarios: `TICK_CYCLES`=4, `DB_TICKS`=3, `SYNC_STAGES`=2, `BTN_ACTIVE_LOW`=1.
- **Reset:** hold `i_rst` for 5 cycles with `i_sw_raw`=0xFFFF_FFFF and `i_btn_raw`=4'hF (released) → all outputs are 0. Deassert `i_rst` → `o_io_sw` = 0xFFFF_FFFF within 11–14 cycles and `o_io_btn` stays 0.
- **Clean press:** drive `i_btn_raw`=4'b1110 and hold → `o_io_btn`=4'b0001 within 11–14 cycles. `o_btn_press`=4'b0001 for exactly one cycle, coincident with the level change. Releasing to 4'hF → `o_io_btn` returns to 0 and no pulse occurs.
- **Bounce:** `i_sw_raw[5]` toggles 1/0 every 3 cycles for 40 cycles, then holds 1 → `o_io_sw[5]` stays 0 during the bounce and goes 1 only after 3 consecutive ticks sample 1.
- **Short glitch:** `i_btn_raw[2]` low for 2 cycles between ticks → `o_io_btn[2]` and `o_btn_press[2]` remain 0.
- **Simultaneous:** switch pattern 0x0000_00A5 and buttons 4'b0101 applied in the same cycle → all accepted on the same tick. `o_btn_press`=4'b1010 for one cycle.
- **Mid-operation reset:** assert `i_rst` asynchronously (between clock edges) 2 ticks into a pending switch change → outputs clear immediately. After release, the change needs a full `DB_TICKS` again before being accepted.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the board-input path: default conditioner sizing and
// the LSU input-buffer offsets within the 0x7800-0x781F window.
package io_pkg;

   localparam int unsigned IO_SW_WIDTH    = 32;
   localparam int unsigned IO_BTN_WIDTH   = 4;
   localparam int unsigned IO_TICK_CYCLES = 500_000;
   localparam int unsigned IO_DB_TICKS    = 4;

   // LSU input-buffer offsets, relative to the 0x7800 base
   localparam logic [4:0] SWITCH_ADDR = 5'h00;
   localparam logic [4:0] BUTTON_ADDR = 5'h10;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchroniser chain followed by a tick-sampled debouncer.
// The level changes only after DB_TICKS consecutive ticks disagree with it.
module debounce_bit
   import io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_TICKS    = IO_DB_TICKS
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int unsigned    CNT_W    = $clog2(DB_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

   logic [SYNC_STAGES-1:0] chain;
   logic [CNT_W-1:0]       cnt;
   logic                   stb;
   logic                   synced;

   assign synced = chain[SYNC_STAGES-1];
   assign level  = stb;

   // Bring the asynchronous pin into the clock domain
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], raw};
      end
   end

   // Count consecutive disagreeing samples; accept the new level on the last one
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stb  <= 1'b0;
         cnt  <= '0;
         rise <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (tick) begin
            if (synced == stb) begin
               cnt <= '0;
            end else if (cnt < CNT_LAST) begin
               cnt <= cnt + CNT_W'(1);
            end else begin
               stb  <= synced;
               cnt  <= '0;
               rise <= synced;
            end
         end
      end
   end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions raw switches and push-buttons for the LSU input buffer:
// button polarity fix-up, a shared sampling prescaler, and one debouncer per bit.
module io_input_conditioner
   import io_pkg::*;
#(
   parameter int unsigned SW_WIDTH       = IO_SW_WIDTH,
   parameter int unsigned BTN_WIDTH      = IO_BTN_WIDTH,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TICK_CYCLES    = IO_TICK_CYCLES,
   parameter int unsigned DB_TICKS       = IO_DB_TICKS,
   parameter int unsigned BTN_ACTIVE_LOW = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [SW_WIDTH-1:0]  i_sw_raw,
   input  logic [BTN_WIDTH-1:0] i_btn_raw,
   output logic [SW_WIDTH-1:0]  o_io_sw,
   output logic [BTN_WIDTH-1:0] o_io_btn,
   output logic [BTN_WIDTH-1:0] o_btn_press
);

   localparam int unsigned      PRE_W    = $clog2(TICK_CYCLES);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

   logic [PRE_W-1:0]     pre_cnt;
   logic                 tick;
   logic [BTN_WIDTH-1:0] btn_act;
   logic [SW_WIDTH-1:0]  sw_rise_unused;

   assign tick    = (pre_cnt == PRE_LAST);
   assign btn_act = (BTN_ACTIVE_LOW != 0) ? ~i_btn_raw : i_btn_raw;

   // Shared sample-tick prescaler, free-running 0..TICK_CYCLES-1
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Switch bits: level only, press pulse not needed
   for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
      debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_TICKS    (DB_TICKS)
      ) u_db (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .tick  (tick),
         .raw   (i_sw_raw[g]),
         .level (o_io_sw[g]),
         .rise  (sw_rise_unused[g])
      );
   end

   // Button bits: active-high level plus press pulse
   for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
      debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_TICKS    (DB_TICKS)
      ) u_db (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .tick  (tick),
         .raw   (btn_act[g]),
         .level (o_io_btn[g]),
         .rise  (o_btn_press[g])
      );
   end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios followed by random pin
// activity, all compared cycle by cycle against a window-based reference model.
module tb_io_input_conditioner;

   localparam int unsigned SW   = 32;
   localparam int unsigned BTN  = 4;
   localparam int unsigned SYNC = 2;
   localparam int unsigned TC   = 4;
   localparam int unsigned DB   = 3;
   localparam int unsigned NB   = SW + BTN;

   logic           clk = 1'b0;
   logic           rst;
   logic [SW-1:0]  sw_raw;
   logic [BTN-1:0] btn_raw;
   logic [SW-1:0]  io_sw;
   logic [BTN-1:0] io_btn;
   logic [BTN-1:0] btn_press;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_input_conditioner #(
      .SW_WIDTH       (SW),
      .BTN_WIDTH      (BTN),
      .SYNC_STAGES    (SYNC),
      .TICK_CYCLES    (TC),
      .DB_TICKS       (DB),
      .BTN_ACTIVE_LOW (1)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_sw_raw    (sw_raw),
      .i_btn_raw   (btn_raw),
      .o_io_sw     (io_sw),
      .o_io_btn    (io_btn),
      .o_btn_press (btn_press)
   );

   // Reference model: pin history, last DB tick samples, accepted levels
   logic [NB-1:0]  hist [$];
   logic [NB-1:0]  win [DB];
   int             since [NB];
   logic [NB-1:0]  m_stb;
   logic [BTN-1:0] m_press;
   int             edge_n;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < DB; k++) win[k] = '0;
      for (int i = 0; i < NB; i++) since[i] = 0;
      m_stb   = '0;
      m_press = '0;
      edge_n  = 0;
   endtask

   // Called once per rising edge; the level a tick sees is the pin value SYNC edges earlier
   task automatic model_step();
      logic [NB-1:0] s;
      logic [NB-1:0] prev;
      bit            all_new;
      prev    = m_stb;
      m_press = '0;
      if (rst) return;
      edge_n++;
      hist.push_back({~btn_raw, sw_raw});
      if (hist.size() > SYNC + 1) void'(hist.pop_front());
      s = (hist.size() > SYNC) ? hist[0] : '0;
      if (edge_n % TC == 0) begin
         for (int k = DB - 1; k > 0; k--) win[k] = win[k-1];
         win[0] = s;
         for (int i = 0; i < NB; i++) begin
            since[i]++;
            all_new = 1'b1;
            for (int k = 0; k < DB; k++) if (win[k][i] == m_stb[i]) all_new = 1'b0;
            if (since[i] >= DB && all_new) begin
               m_stb[i] = ~m_stb[i];
               since[i] = 0;
            end
         end
         m_press = m_stb[NB-1:SW] & ~prev[NB-1:SW];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_sw",    64'(io_sw),     64'(m_stb[SW-1:0]));
      chk("model_btn",   64'(io_btn),    64'(m_stb[NB-1:SW]));
      chk("model_press", 64'(btn_press), 64'(m_press));
   endtask

   initial begin
      int n;
      int lat;
      int pulses;
      int sw_first;
      int btn_first;
      bit found;
      bit stayed;
      logic [SW-1:0]  sw_mask;
      logic [BTN-1:0] btn_mask;

      // Reset with switches high and buttons released
      rst     = 1'b1;
      sw_raw  = '1;
      btn_raw = '1;
      model_reset();
      repeat (5) cyc();
      chk("reset_sw",    64'(io_sw),     64'(0));
      chk("reset_btn",   64'(io_btn),    64'(0));
      chk("reset_press", 64'(btn_press), 64'(0));

      rst   = 1'b0;
      n     = 0;
      found = 1'b0;
      while (!found && n < 20) begin
         cyc();
         n++;
         if (io_sw == '1) found = 1'b1;
         chk("rst_btn_quiet", 64'(io_btn), 64'(0));
      end
      chk("rst_sw_latency_ok", 64'(found && n >= 11 && n <= 14), 64'(1));

      // Clean press of button 0, then release
      btn_raw = 4'b1110;
      n       = 0;
      lat     = 0;
      found   = 1'b0;
      pulses  = 0;
      while (n < 20) begin
         cyc();
         n++;
         if (btn_press != '0) pulses++;
         if (!found && io_btn == 4'b0001) begin
            found = 1'b1;
            lat   = n;
            chk("press_pulse_coincident", 64'(btn_press), 64'(4'b0001));
         end
      end
      chk("press_latency_ok",  64'(found && lat >= 11 && lat <= 14), 64'(1));
      chk("press_pulse_count", 64'(pulses), 64'(1));
      chk("press_level",       64'(io_btn), 64'(4'b0001));

      btn_raw = 4'hF;
      pulses  = 0;
      repeat (20) begin
         cyc();
         if (btn_press != '0) pulses++;
      end
      chk("release_level",    64'(io_btn), 64'(0));
      chk("release_no_pulse", 64'(pulses), 64'(0));

      // Bounce on switch 5
      sw_raw[5] = 1'b0;
      repeat (20) cyc();
      chk("bounce_pre_low", 64'(io_sw[5]), 64'(0));
      stayed = 1'b1;
      for (int t = 0; t < 40; t++) begin
         sw_raw[5] = ((t / 3) % 2 == 0);
         cyc();
         if (io_sw[5]) stayed = 1'b0;
      end
      chk("bounce_held_low", 64'(stayed), 64'(1));
      sw_raw[5] = 1'b1;
      n     = 0;
      found = 1'b0;
      while (!found && n < 20) begin
         cyc();
         n++;
         if (io_sw[5]) found = 1'b1;
      end
      chk("bounce_settle", 64'(found && n <= 14), 64'(1));

      // Two-cycle glitch on button 2 placed between tick samples
      while (edge_n % TC != 2) cyc();
      btn_raw[2] = 1'b0;
      cyc();
      cyc();
      btn_raw[2] = 1'b1;
      stayed = 1'b1;
      repeat (20) begin
         cyc();
         if (io_btn[2] || btn_press[2]) stayed = 1'b0;
      end
      chk("glitch_ignored", 64'(stayed), 64'(1));

      // Simultaneous switch and button changes
      sw_raw = '0;
      repeat (20) cyc();
      chk("simul_pre_sw", 64'(io_sw), 64'(0));
      sw_raw    = 32'h0000_00A5;
      btn_raw   = 4'b0101;
      sw_first  = -1;
      btn_first = -1;
      n         = 0;
      while (btn_first < 0 && n < 20) begin
         cyc();
         n++;
         if (sw_first < 0 && io_sw != '0) sw_first = n;
         if (io_btn != '0) begin
            btn_first = n;
            chk("simul_btn",   64'(io_btn),    64'(4'b1010));
            chk("simul_sw",    64'(io_sw),     64'(32'h0000_00A5));
            chk("simul_press", 64'(btn_press), 64'(4'b1010));
         end
      end
      chk("simul_same_cycle", 64'(sw_first == btn_first && btn_first > 0), 64'(1));
      cyc();
      chk("simul_press_one_cycle", 64'(btn_press), 64'(0));

      // Asynchronous reset two ticks into a pending switch change
      while (edge_n % TC != 0) cyc();
      sw_raw = 32'h0000_005A;
      repeat (9) cyc();
      chk("mid_pending", 64'(io_sw), 64'(32'h0000_00A5));
      @(posedge clk);
      model_step();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_sw",    64'(io_sw),     64'(0));
      chk("mid_rst_btn",   64'(io_btn),    64'(0));
      chk("mid_rst_press", 64'(btn_press), 64'(0));
      @(negedge clk);
      repeat (2) cyc();
      rst   = 1'b0;
      n     = 0;
      found = 1'b0;
      while (!found && n < 20) begin
         cyc();
         n++;
         if (io_sw == 32'h0000_005A) found = 1'b1;
      end
      chk("mid_full_restart", 64'(found && n >= 11 && n <= 14), 64'(1));

      // Random pin activity, including short glitches and multi-bit changes
      for (int r = 0; r < 3000; r++) begin
         if ($urandom_range(0, 7) == 0) begin
            sw_mask  = SW'(1) << $urandom_range(0, SW - 1);
            if ($urandom_range(0, 3) == 0) sw_mask = sw_mask | SW'($urandom());
            btn_mask = BTN'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) sw_raw = sw_raw ^ sw_mask;
            else btn_raw = btn_raw ^ btn_mask;
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
